bit_serial_adder: RTL
=====================

# bit_serial_adder

Sequential LSB-first adder/subtractor built around a single 1-bit full-adder cell with a registered carry. It sits directly upstream of the full-adder stage: it registers two WIDTH-bit operands, feeds the cell one bit pair per clock, and collects the sum bits into a result register. Handshake is start/busy/done, so a controller or testbench can issue operations back-to-back.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request operation; sampled only when idle
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result registers just updated
- s  output  WIDTH  sum/difference, held until next completion
- cOut  output  1  final carry out of MSB (subtract: 1 = no borrow)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, SHIFT.
- IDLE, start=1: load opA←a, opB←(sub ? ~b : b), carry←sub, bit counter←0, partial-sum register cleared; go to SHIFT.
- IDLE, start=0: hold.
- SHIFT, each cycle: full-adder cell takes opA[0], opB[0], carry. Sum bit shifts into the MSB of the partial-sum register, which shifts right. carry←cell cOut. opA and opB shift right. Counter increments.
- When the counter reaches WIDTH−1: latch the carry into the MSB as carryMsb (this is the carry-in of the MSB position).
- Last bit (counter = WIDTH−1):
  - s←final partial sum, cOut←cell cOut, overflow←carryMsb XOR cell cOut.
  - done←1; return to IDLE.
- start while busy=1 is ignored and not queued. a, b and sub may change freely while busy.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement, with carry-in 1 and B inverted.
- Reset (rst=0, any time, including mid-operation): state IDLE; busy=0, done=0, s=0, cOut=0, overflow=0. All internal registers are cleared. An aborted operation produces no done pulse.

## Timing
- Let E0 be the edge at which start=1 is sampled in IDLE.
- busy=1 from just after E0 through the edge E_WIDTH.
- Bits are processed on edges E1 through E_WIDTH.
- At E_WIDTH:
  - s, cOut and overflow update.
  - done=1 for exactly one cycle.
  - busy=0.
- Latency from E0 to valid result is WIDTH edges. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- start=1 during the done cycle (state IDLE) is accepted at the next edge. done then falls and busy rises on that same edge.
- Between completions, s, cOut and overflow are stable. They do not show partial results.

## Test plan
- Reset, then WIDTH=8 add: a=0x35, b=0x4A → after 8 edges, done pulse; s=0x7F, cOut=0, overflow=0; busy high for exactly 8 cycles.
- Add carry and overflow cases:
  - 0x7F+0x01 → s=0x80, cOut=0, overflow=1.
  - 0xFF+0x01 → s=0x00, cOut=1, overflow=0.
- Subtract cases:
  - sub=1, 0x10−0x20 → s=0xF0, cOut=0, overflow=0.
  - 0x80−0x01 → s=0x7F, cOut=1, overflow=1.
- Start ignored while busy: pulse start with different a/b at cycle 3 of an operation → result matches the first operands only; exactly one done pulse; no second operation starts.
- Back-to-back:
  - Assert start during the done cycle with 0x01+0x02 → new operation begins next edge; s=0x03 after 8 more edges.
  - Previous s is held until then.
- Reset mid-operation: drop rst at cycle 4 of 0xAA+0x55 → outputs immediately 0, busy=0; no done pulse after release; next operation computes correctly.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for the bit-serial adder. The controller side drives
// the request (start, sub, a, b). The adder side returns status and result.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cOut;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, s, cOut, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, s, cOut, overflow
    );
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder/subtractor built on one full-adder cell with a
// registered carry. Operands are captured on start. One bit pair is consumed
// per clock. The result registers only change on the final bit, so s, cOut
// and overflow never show partial sums.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST = CW'(WIDTH - 2);

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } stateType;

    stateType         state;
    stateType         nextState;
    logic             loadOps;
    logic             lastBit;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             carry;
    logic             carryMsb;
    logic [CW-1:0]    bitCount;
    logic [WIDTH-1:0] partial;

    logic [WIDTH-1:0] sReg;
    logic             cOutReg;
    logic             overflowReg;
    logic             doneReg;

    logic             sumBit;
    logic             cellCout;

    // Single full-adder cell fed by the low bits of the shifting operands
    always_comb begin
        sumBit   = opA[0] ^ opB[0] ^ carry;
        cellCout = (opA[0] & opB[0]) | (carry & (opA[0] ^ opB[0]));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: accept start only when idle, finish on the MSB
    always_comb begin
        nextState = state;
        loadOps   = 1'b0;
        lastBit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    loadOps   = 1'b1;
                    nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (bitCount == LAST) begin
                    lastBit   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Operand shifting, carry chain and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opA      <= '0;
            opB      <= '0;
            carry    <= 1'b0;
            carryMsb <= 1'b0;
            bitCount <= '0;
            partial  <= '0;
        end else if (loadOps) begin
            opA      <= bus.a;
            opB      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            carryMsb <= 1'b0;
            bitCount <= '0;
            partial  <= '0;
        end else if (state == SHIFT) begin
            partial  <= {sumBit, partial[WIDTH-1:1]};
            opA      <= opA >> 1;
            opB      <= opB >> 1;
            carry    <= cellCout;
            if (!lastBit) begin
                bitCount <= bitCount + CW'(1);
            end
            if (bitCount == PRELAST) begin
                carryMsb <= cellCout;
            end
        end
    end

    // Result registers: updated only on the final bit, with a one-cycle done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sReg        <= '0;
            cOutReg     <= 1'b0;
            overflowReg <= 1'b0;
            doneReg     <= 1'b0;
        end else begin
            doneReg <= lastBit;
            if (lastBit) begin
                sReg        <= {sumBit, partial[WIDTH-1:1]};
                cOutReg     <= cellCout;
                overflowReg <= carryMsb ^ cellCout;
            end
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = doneReg;
    assign bus.s        = sReg;
    assign bus.cOut     = cOutReg;
    assign bus.overflow = overflowReg;
endmodule
